// File: rtl/btb_update_queue_pkg.sv
// Shared BTB update types, widths and the PC-to-BTB-word packing helper.
// Each width can be overridden by defining its macro before this file is compiled.
`ifndef ENTRY_PC
`define ENTRY_PC 32
`endif
`ifndef CAM_BITS
`define CAM_BITS 8
`endif
`ifndef TARGET_BITS
`define TARGET_BITS 16
`endif

package btb_update_queue_pkg;

    localparam int ENTRY_PC    = `ENTRY_PC;
    localparam int IDX         = $clog2(ENTRY_PC);
    localparam int CAM_BITS    = `CAM_BITS;
    localparam int TARGET_BITS = `TARGET_BITS;
    localparam int WORD_BITS   = IDX + CAM_BITS;

    typedef struct packed {
        logic                   valid;
        logic [CAM_BITS-1:0]    tag;
        logic [IDX-1:0]         idx;
        logic [TARGET_BITS-1:0] target;
    } btb_upd_packet_t;

    // {tag,idx} is the contiguous slice pc[IDX+CAM_BITS+1:2]; byte offset and upper PC bits are ignored.
    function automatic logic [WORD_BITS-1:0] pc_to_btb_word(input logic [63:0] pc);
        logic unused_pc_bits;
        unused_pc_bits = ^{pc[63:WORD_BITS+2], pc[1:0]};
        return pc[WORD_BITS+1:2];
    endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// Execute-side update bus and BTB-side write port of the update queue.
interface btb_update_queue_if;
    import btb_update_queue_pkg::*;

    logic                   ex_valid;
    logic [63:0]            ex_pc;
    logic [TARGET_BITS-1:0] ex_tgt;
    logic                   drain_en;
    logic                   exe_pc_valid;
    logic [WORD_BITS-1:0]   PC_from_exe;
    logic [TARGET_BITS-1:0] ex_target;
    logic                   q_full;
    logic                   q_empty;
    logic [15:0]            drop_cnt;

    modport master (
        output ex_valid, ex_pc, ex_tgt, drain_en,
        input  exe_pc_valid, PC_from_exe, ex_target, q_full, q_empty, drop_cnt
    );

    modport slave (
        input  ex_valid, ex_pc, ex_tgt, drain_en,
        output exe_pc_valid, PC_from_exe, ex_target, q_full, q_empty, drop_cnt
    );
endinterface

// File: rtl/btb_update_queue_match.sv
// DEPTH-way index compare against the queued updates; reports the youngest valid match.
module btb_upd_match
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [IDX-1:0]           idx_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [IDX-1:0]           cmp_idx_i,
    output logic                     hit_o,
    output logic [DEPTH-1:0]         match_oh_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest so a later match replaces an earlier one.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        hit_o      = 1'b0;
        match_oh_o = '0;
        slot       = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && idx_i[slot] == cmp_idx_i) begin
                hit_o            = 1'b1;
                match_oh_o       = '0;
                match_oh_o[slot] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/btb_update_queue.sv
// Coalescing FIFO of resolved taken-branch updates, drained one per cycle into the BTB write port.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               clock,
    input logic               reset,
    btb_update_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    btb_upd_packet_t  entry_q [DEPTH];
    btb_upd_packet_t  entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      drop_q, drop_d;

    logic [CAM_BITS-1:0] in_tag;
    logic [IDX-1:0]      in_idx;
    logic [DEPTH-1:0]    valid_vec;
    logic [IDX-1:0]      idx_vec [DEPTH];
    logic                hit;
    logic [DEPTH-1:0]    match_oh;
    logic                empty, full, pop, coalesce, push, drop;

    assign {in_tag, in_idx} = pc_to_btb_word(bus.ex_pc);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entry_q[i].valid;
            idx_vec[i]   = entry_q[i].idx;
        end
    end

    btb_upd_match #(.DEPTH(DEPTH)) u_match (
        .valid_i    (valid_vec),
        .idx_i      (idx_vec),
        .head_i     (head_q),
        .cmp_idx_i  (in_idx),
        .hit_o      (hit),
        .match_oh_o (match_oh)
    );

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = !empty && bus.drain_en;
    // A match on the head that leaves this cycle would be lost, so it is queued afresh instead.
    assign coalesce = bus.ex_valid && hit && !(pop && match_oh[head_q]);
    assign push     = bus.ex_valid && !coalesce && (!full || pop);
    assign drop     = bus.ex_valid && !coalesce && full && !pop;

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        drop_d  = drop_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (coalesce && match_oh[j]) begin
                entry_d[j].tag    = in_tag;
                entry_d[j].target = bus.ex_tgt;
            end
        end
        if (pop) begin
            entry_d[head_q].valid = 1'b0;
            head_d                = head_q + PTR_W'(1);
        end
        // Applied after the pop: when full, tail equals head and the new entry must win.
        if (push) begin
            entry_d[tail_q] = '{valid: 1'b1, tag: in_tag, idx: in_idx, target: bus.ex_tgt};
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // NOTE: the entry array is only DEPTH deep, so the whole array is reset to keep the head output deterministic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.exe_pc_valid = pop;
    assign bus.PC_from_exe  = empty ? '0 : {entry_q[head_q].tag, entry_q[head_q].idx};
    assign bus.ex_target    = empty ? '0 : entry_q[head_q].target;
    assign bus.q_full       = full;
    assign bus.q_empty      = empty;
    assign bus.drop_cnt     = drop_q;
endmodule
